// File: rtl/meteo_display_seq_pkg.sv
// Shared types for the meteo display back-end: FSM states, 7-segment codes
// (active-low {g,f,e,d,c,b,a}) and width helpers.
package meteo_display_seq_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_e;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Register width able to hold 0..n-1, never narrower than one bit.
  function automatic int cw(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/meteo_display_seq_if.sv
// Sensor-side inputs and display-side outputs of the meteo display back-end.
interface meteo_display_seq_if #(
  parameter int NCH  = 3,
  parameter int DW   = 20,
  parameter int NDIG = 6
);
  import meteo_display_seq_pkg::*;
  localparam int CHW = cw(NCH);

  logic [NCH*DW-1:0] Data_i;
  logic [NCH-1:0]    Upd_i;
  logic              Mode_i;
  logic [NCH-1:0]    Sel_i;
  logic              Blank_i;
  logic [6:0]        Seg_o;
  logic [NDIG-1:0]   Dig_o;
  logic [CHW-1:0]    Ch_o;
  logic              Ovf_o;
  logic              Busy_o;

  modport slave  (input  Data_i, Upd_i, Mode_i, Sel_i, Blank_i,
                  output Seg_o, Dig_o, Ch_o, Ovf_o, Busy_o);
  modport master (output Data_i, Upd_i, Mode_i, Sel_i, Blank_i,
                  input  Seg_o, Dig_o, Ch_o, Ovf_o, Busy_o);
endinterface

// File: rtl/meteo_display_seq_bcd_serial_conv.sv
// Serial double-dabble: Start loads Bin, then one bit per clock for DW clocks.
// Done is high during the final shift cycle; Bcd/Ovf are final the clock after.
module bcd_serial_conv
  import meteo_display_seq_pkg::*;
#(
  parameter int DW = 20,
  parameter int ND = 7
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Start,
  input  logic [DW-1:0]   Bin,
  output logic [4*ND-1:0] Bcd,
  output logic            Ovf,
  output logic            Done
);
  localparam int CW = cw(DW + 1);

  logic [DW-1:0]   bin_q;
  logic [4*ND-1:0] acc_q;
  logic [4*ND-1:0] adj_d;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q;

  always_comb begin
    adj_d = acc_q;
    for (int i = 0; i < ND; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bin_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (Start) begin
      bin_q <= Bin;
      acc_q <= '0;
      cnt_q <= CW'(DW);
      ovf_q <= 1'b0;
    end else if (cnt_q != '0) begin
      acc_q <= {adj_d[4*ND-2:0], bin_q[DW-1]};
      bin_q <= {bin_q[DW-2:0], 1'b0};
      ovf_q <= ovf_q | adj_d[4*ND-1];
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign Done = (cnt_q == CW'(1));
  assign Bcd  = acc_q;
  assign Ovf  = ovf_q;
endmodule

// File: rtl/meteo_display_seq.sv
// Meteo display back-end: channel select/rotate, serial BCD conversion and a
// multiplexed active-low 7-seg scan. Trigger to display update is DW+3 clocks.
module meteo_display_seq
  import meteo_display_seq_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int DW       = 20,
  parameter int NDIG     = 6,
  parameter int DWELL    = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input logic                Clk,
  input logic                Rst,
  meteo_display_seq_if.slave bus
);
  localparam int CHW = cw(NCH);
  localparam int IDW = cw(NDIG);
  localparam int DWW = cw(DWELL);
  localparam int SCW = cw(SCAN_DIV);

  state_e            state_q;
  logic              pend_q, ovf_q, mode_q;
  logic [CHW-1:0]    ch_q, ch_d, sel_idx;
  logic              sel_any, trig, go, dwell_tc;
  logic [DWW-1:0]    dwell_q;
  logic [DW-1:0]     data_sel;
  logic [4*NDIG-1:0] disp_q;
  logic [4*NDIG+3:0] cvt_bcd;
  logic              cvt_ovf, cvt_done;
  logic [SCW-1:0]    presc_q;
  logic [IDW-1:0]    idx_q;
  logic [6:0]        seg_q, seg_d;
  logic [NDIG-1:0]   dig_q;
  logic [3:0]        dsel;
  logic              zero_above;

  always_comb begin
    sel_idx  = '0;
    sel_any  = 1'b0;
    data_sel = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (bus.Sel_i[k]) begin
        sel_idx = CHW'(k);
        sel_any = 1'b1;
      end
    end
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == CHW'(k)) data_sel = bus.Data_i[k*DW +: DW];
    end
  end

  assign dwell_tc = (dwell_q == DWW'(DWELL - 1));

  always_comb begin
    ch_d = ch_q;
    if (!bus.Mode_i) begin
      if (sel_any) ch_d = sel_idx;
    end else if (mode_q && dwell_tc) begin
      ch_d = (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + CHW'(1);
    end
  end

  assign trig = (ch_d != ch_q) | (|(bus.Upd_i & (NCH'(1) << ch_q)));
  assign go   = pend_q | trig;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      dwell_q <= '0;
      mode_q  <= 1'b0;
      ch_q    <= '0;
    end else begin
      mode_q <= bus.Mode_i;
      ch_q   <= ch_d;
      if (!bus.Mode_i || !mode_q || dwell_tc) dwell_q <= '0;
      else                                     dwell_q <= dwell_q + DWW'(1);
    end
  end

  // Triggers seen while busy fold into one pending re-conversion.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pend_q <= 1'b0;
          if (go) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          pend_q  <= pend_q | trig;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          pend_q <= pend_q | trig;
          if (cvt_done) state_q <= ST_DONE;
        end
        default: begin
          pend_q  <= pend_q | trig;
          disp_q  <= cvt_bcd[4*NDIG-1:0];
          ovf_q   <= cvt_ovf | (cvt_bcd[4*NDIG +: 4] != 4'd0);
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  bcd_serial_conv #(.DW(DW), .ND(NDIG + 1)) u_conv (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (state_q == ST_LOAD),
    .Bin   (data_sel),
    .Bcd   (cvt_bcd),
    .Ovf   (cvt_ovf),
    .Done  (cvt_done)
  );

  always_comb begin
    dsel       = 4'd0;
    zero_above = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (IDW'(i) == idx_q) dsel = disp_q[4*i +: 4];
      if (IDW'(i) >= idx_q && disp_q[4*i +: 4] != 4'd0) zero_above = 1'b0;
    end
    if (!bus.Mode_i && !sel_any)                       seg_d = SEG_OFF;
    else if (ovf_q)                                    seg_d = SEG_DASH;
    else if (bus.Blank_i && idx_q != '0 && zero_above) seg_d = SEG_OFF;
    else                                               seg_d = seg_decode(dsel);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      dig_q   <= '1;
    end else begin
      if (presc_q == SCW'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        idx_q   <= (idx_q == IDW'(NDIG - 1)) ? '0 : idx_q + IDW'(1);
      end else begin
        presc_q <= presc_q + SCW'(1);
      end
      seg_q <= seg_d;
      dig_q <= ~(NDIG'(1) << idx_q);
    end
  end

  assign bus.Seg_o  = seg_q;
  assign bus.Dig_o  = dig_q;
  assign bus.Ch_o   = ch_q;
  assign bus.Ovf_o  = ovf_q;
  assign bus.Busy_o = (state_q != ST_IDLE);
endmodule

// File: tb/tb_meteo_display_seq.sv
// Randomized scoreboard bench for meteo_display_seq: expected displays come
// from a decimal-arithmetic model and are checked by a scan monitor.
module tb_meteo_display_seq;
  localparam int NCH = 3, DW = 20, NDIG = 6, DWELL = 8, SCAN_DIV = 4;

  typedef struct packed {
    logic [1:0]            ch;
    logic                  ovf;
    logic [NDIG-1:0][6:0]  seg;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  meteo_display_seq_if #(.NCH(NCH), .DW(DW), .NDIG(NDIG)) dif ();

  meteo_display_seq #(.NCH(NCH), .DW(DW), .NDIG(NDIG), .DWELL(DWELL), .SCAN_DIV(SCAN_DIV)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (dif)
  );

  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [DW-1:0] vals [NCH];
  exp_t q [$];
  int checks = 0, failures = 0, done_cnt = 0, exp_n = 0, cur_ch = 0;
  bit skip = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input int ch, input int v, input bit blank);
    exp_t e;
    int d [NDIG];
    int lim = 1, p = v, msnz = 0;
    for (int i = 0; i < NDIG; i++) lim = lim * 10;
    e.ch  = 2'(ch);
    e.ovf = (v >= lim);
    for (int i = 0; i < NDIG; i++) begin
      d[i] = p % 10;
      p    = p / 10;
      if (d[i] != 0) msnz = i;
    end
    for (int i = 0; i < NDIG; i++)
      e.seg[i] = e.ovf ? 7'h3F : ((blank && i > msnz) ? 7'h7F : segtab[d[i]]);
    return e;
  endfunction

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_data();
    for (int k = 0; k < NCH; k++) dif.Data_i[k*DW +: DW] = vals[k];
  endtask

  task automatic wait_done();
    int c = 0;
    while (done_cnt < exp_n && c < 400) begin
      @(posedge clk);
      c++;
    end
    chk("conv_done", 64'(done_cnt), 64'(exp_n));
  endtask

  task automatic check_quiet(input string name, input int n);
    bit seen_busy = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (dif.Busy_o) seen_busy = 1'b1;
    end
    chk(name, 64'(seen_busy), 64'(0));
  endtask

  task automatic scan_check(input string name, input logic [NDIG-1:0][6:0] expv);
    logic [NDIG-1:0] seen = '0;
    logic [NDIG-1:0][6:0] got = '0;
    int c = 0;
    @(negedge clk);
    @(negedge clk);
    while (seen != '1 && c < 4*NDIG*SCAN_DIV) begin
      @(negedge clk);
      c++;
      for (int i = 0; i < NDIG; i++)
        if (dif.Dig_o == ~(NDIG'(1) << i)) begin got[i] = dif.Seg_o; seen[i] = 1'b1; end
    end
    chk(name, 64'(got), 64'(expv));
  endtask

  task automatic issue(input int ch, input int val, input bit blank, input bit pulse);
    at_pos();
    vals[ch] = DW'(val);
    drive_data();
    dif.Sel_i   = NCH'(1) << ch;
    dif.Blank_i = blank;
    if (pulse) dif.Upd_i = NCH'(1) << ch;
    q.push_back(model(ch, val, blank));
    exp_n++;
    at_pos();
    dif.Upd_i = '0;
    wait_done();
    cur_ch = ch;
  endtask

  // Scoreboard monitor: each completed conversion pops one expectation.
  initial begin : monitor
    bit prev = 1'b0, sampling = 1'b0;
    int scnt = 0;
    logic [NDIG-1:0] seen = '0;
    logic [NDIG-1:0][6:0] got = '0;
    exp_t cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        sampling = 1'b0;
      end else begin
        if (sampling) begin
          scnt++;
          for (int i = 0; i < NDIG; i++)
            if (dif.Dig_o == ~(NDIG'(1) << i) && !seen[i]) begin got[i] = dif.Seg_o; seen[i] = 1'b1; end
          if (seen == '1) begin
            chk("scan_digits", 64'(got), 64'(cur.seg));
            sampling = 1'b0;
            done_cnt++;
          end else if (scnt > 4*NDIG*SCAN_DIV) begin
            chk("scan_timeout", 64'(seen), 64'({NDIG{1'b1}}));
            sampling = 1'b0;
            done_cnt++;
          end
        end
        if (prev && !dif.Busy_o && !skip) begin
          if (q.size() == 0) begin
            chk("unexpected_conversion", 64'(q.size()), 64'(1));
          end else begin
            cur = q.pop_front();
            chk("conv_ch", 64'(dif.Ch_o), 64'(cur.ch));
            chk("conv_ovf", 64'(dif.Ovf_o), 64'(cur.ovf));
            sampling = 1'b1;
            scnt = 0;
            seen = '0;
          end
        end
        prev = dif.Busy_o;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1);
  end

  initial begin : stim
    int lat, lowcnt, c, ch, val, kind;
    rst = 1'b1;
    dif.Data_i = '0; dif.Upd_i = '0; dif.Mode_i = 1'b0; dif.Sel_i = '0; dif.Blank_i = 1'b0;
    for (int k = 0; k < NCH; k++) vals[k] = '0;
    #1;
    chk("rst_seg", 64'(dif.Seg_o), 64'(7'h7F));
    chk("rst_dig", 64'(dif.Dig_o), 64'({NDIG{1'b1}}));
    chk("rst_ch", 64'(dif.Ch_o), 64'(0));
    chk("rst_ovf", 64'(dif.Ovf_o), 64'(0));
    chk("rst_busy", 64'(dif.Busy_o), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // T1: manual select of ch1 with a fresh value, plus trigger latency
    at_pos();
    vals[1] = 20'd123456; drive_data();
    dif.Sel_i = 3'b010; dif.Upd_i = 3'b010;
    q.push_back(model(1, 123456, 1'b0)); exp_n++;
    at_pos();
    dif.Upd_i = '0;
    chk("t1_busy_rise", 64'(dif.Busy_o), 64'(1));
    lat = 1;
    while (dif.Busy_o && lat < 100) begin at_pos(); lat++; end
    chk("t1_latency", 64'(lat), 64'(DW + 3));
    wait_done();
    cur_ch = 1;

    // T2: overflow and recovery
    issue(1, 1000000, 1'b0, 1'b1);
    issue(1, 999999, 1'b0, 1'b1);

    // Sel_i == 0: channel holds, display blank
    at_pos();
    dif.Sel_i = '0;
    repeat (3) at_pos();
    chk("sel0_ch_hold", 64'(dif.Ch_o), 64'(1));
    scan_check("sel0_blank", {NDIG{7'h7F}});

    // T3: leading-zero blanking
    issue(0, 42, 1'b1, 1'b0);
    issue(0, 0, 1'b1, 1'b1);

    // Updates on non-shown channels are ignored
    at_pos();
    dif.Upd_i = 3'b110;
    at_pos();
    dif.Upd_i = '0;
    check_quiet("no_conv_other_ch", 30);

    // T4: auto rotation every DWELL clocks starting from the current channel
    skip = 1'b1;
    at_pos();
    dif.Mode_i = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      repeat ((s == 1) ? DWELL : DWELL - 1) at_pos();
      chk("auto_hold", 64'(dif.Ch_o), 64'((s - 1) % NCH));
      at_pos();
      chk("auto_step", 64'(dif.Ch_o), 64'(s % NCH));
    end
    at_pos();
    dif.Mode_i = 1'b0;
    dif.Sel_i  = 3'b010;
    lowcnt = 0; c = 0;
    while (lowcnt < 3 && c < 300) begin
      @(negedge clk);
      c++;
      lowcnt = dif.Busy_o ? 0 : lowcnt + 1;
    end
    chk("auto_exit_settle", 64'(lowcnt), 64'(3));
    skip = 1'b0;
    cur_ch = 1;

    // T5: three triggers during SHIFT collapse into one re-conversion
    at_pos();
    vals[1] = 20'd314159; drive_data();
    dif.Upd_i = 3'b010;
    q.push_back(model(1, 314159, 1'b0)); exp_n++;
    at_pos();
    dif.Upd_i = '0;
    repeat (3) at_pos();
    for (int j = 0; j < 3; j++) begin
      vals[1] = DW'(271000 + j * 11); drive_data();
      dif.Upd_i = 3'b010;
      at_pos();
      dif.Upd_i = '0;
      at_pos();
    end
    q.push_back(model(1, 271022, 1'b0)); exp_n++;
    wait_done();
    check_quiet("t5_single_extra", 30);

    // Randomized conversions in manual mode
    for (int n = 0; n < 10; n++) begin
      ch   = $urandom_range(0, NCH - 1);
      kind = $urandom_range(0, 2);
      if (kind == 0)      val = $urandom_range(0, 1048575);
      else if (kind == 1) val = $urandom_range(0, 999);
      else                val = $urandom_range(999990, 1000010);
      issue(ch, val, 1'($urandom_range(0, 1)), (ch == cur_ch) ? 1'b1 : 1'($urandom_range(0, 1)));
    end

    // T6: reset in the middle of SHIFT
    at_pos();
    vals[2] = 20'd777777; drive_data();
    dif.Sel_i = 3'b100; dif.Blank_i = 1'b0;
    repeat (5) at_pos();
    dif.Sel_i = 3'b001;
    rst = 1'b1;
    #1;
    chk("t6_seg", 64'(dif.Seg_o), 64'(7'h7F));
    chk("t6_dig", 64'(dif.Dig_o), 64'({NDIG{1'b1}}));
    chk("t6_ch", 64'(dif.Ch_o), 64'(0));
    chk("t6_ovf", 64'(dif.Ovf_o), 64'(0));
    chk("t6_busy", 64'(dif.Busy_o), 64'(0));
    repeat (2) at_pos();
    rst = 1'b0;
    check_quiet("t6_no_conv", 30);
    scan_check("t6_display_zero", {NDIG{7'h40}});
    chk("t6_ovf_after", 64'(dif.Ovf_o), 64'(0));
    chk("queue_empty", 64'(q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
